// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared constants, types and helpers for the register file write arbiter
package regfile_wb_arbiter_pkg;

  localparam int DATA_WID       = 32;
  localparam int REGS_WID       = 5;
  localparam int NUM_REGS       = 32;
  localparam int STARVE_CNT_WID = 4;

  localparam logic [STARVE_CNT_WID-1:0] STARVE_CNT_MAX = '1;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } arb_state_e;

  // x0 is hardwired zero, so writes to it are dropped and it never carries a hazard
  function automatic logic rd_nonzero(input logic [REGS_WID-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// rtl/regfile_wb_arbiter_scoreboard.sv - pending long-latency write scoreboard (reg_scoreboard)
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   iss_valid_i, iss_long_i   decode issue and "completes through B" flag
//   iss_rs1_i/rs2_i/rd_i      issuing instruction operands
//   clr_valid_i, clr_rd_i     B transfer clearing a pending register
//   hazard_o                  issuing instruction must stall (ungated by reset)
module reg_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                iss_valid_i,
  input  logic                iss_long_i,
  input  logic [REGS_WID-1:0] iss_rs1_i,
  input  logic [REGS_WID-1:0] iss_rs2_i,
  input  logic [REGS_WID-1:0] iss_rd_i,
  input  logic                clr_valid_i,
  input  logic [REGS_WID-1:0] clr_rd_i,
  output logic                hazard_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                set_en;

  // No same-cycle bypass: hazard looks only at registered busy bits
  assign hazard_o = iss_valid_i &
                    (busy_q[iss_rs1_i] | busy_q[iss_rs2_i] |
                     (busy_q[iss_rd_i] & rd_nonzero(iss_rd_i)));

  assign set_en = iss_valid_i & iss_long_i & ~hazard_o & rd_nonzero(iss_rd_i);

  always_comb begin
    busy_d = busy_q;
    if (clr_valid_i) busy_d[clr_rd_i] = 1'b0;
    // Set is applied after clear so a new producer wins over a retiring one
    if (set_en)      busy_d[iss_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter with starvation relief and hazard scoreboard
//
// Ports:
//   clk_i, rst_ni                         clock, asynchronous active-low reset
//   a_valid_i, a_rd_i, a_data_i           pipeline writeback (no backpressure)
//   b_valid_i, b_ready_o, b_rd_i, b_data_i  long-latency completion handshake
//   iss_*_i, hazard_o                     decode issue and stall
//   pipe_freeze_o                         hold pipeline writeback this cycle
//   rf_we_o, rf_waddr_o, rf_wdata_o       register file write port
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                a_valid_i,
  input  logic [REGS_WID-1:0] a_rd_i,
  input  logic [DATA_WID-1:0] a_data_i,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic [REGS_WID-1:0] b_rd_i,
  input  logic [DATA_WID-1:0] b_data_i,
  input  logic                iss_valid_i,
  input  logic                iss_long_i,
  input  logic [REGS_WID-1:0] iss_rs1_i,
  input  logic [REGS_WID-1:0] iss_rs2_i,
  input  logic [REGS_WID-1:0] iss_rd_i,
  output logic                hazard_o,
  output logic                pipe_freeze_o,
  output logic                rf_we_o,
  output logic [REGS_WID-1:0] rf_waddr_o,
  output logic [DATA_WID-1:0] rf_wdata_o
);

  localparam logic [STARVE_CNT_WID-1:0] STARVE_LAST = STARVE_CNT_WID'(STARVE_LIMIT - 1);

  arb_state_e                state_q, state_d;
  logic [STARVE_CNT_WID-1:0] starve_cnt_q, starve_cnt_d;
  logic                      force_b;
  logic                      sel_b;
  logic                      b_ready;
  logic                      b_xfer;
  logic                      b_blocked;
  logic                      hazard_raw;

  assign force_b   = (state_q == ST_FORCE);
  assign b_xfer    = b_valid_i & b_ready_o;
  assign b_blocked = b_valid_i & ~b_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_NORMAL;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = ST_NORMAL;
    starve_cnt_d = starve_cnt_q;
    if (state_q == ST_NORMAL && b_blocked && starve_cnt_q == STARVE_LAST) state_d = ST_FORCE;
    if (!b_valid_i || b_xfer)                  starve_cnt_d = '0;
    else if (starve_cnt_q != STARVE_CNT_MAX)   starve_cnt_d = starve_cnt_q + 1'b1;
  end

  // FORCE hands the port to B for one cycle; the pipeline replays A afterwards
  always_comb begin
    sel_b   = ~a_valid_i;
    b_ready = ~a_valid_i;
    if (force_b) begin
      sel_b   = 1'b1;
      b_ready = 1'b1;
    end
  end

  assign pipe_freeze_o = force_b;
  assign b_ready_o     = rst_ni & b_ready;
  assign rf_waddr_o    = sel_b ? b_rd_i   : a_rd_i;
  assign rf_wdata_o    = sel_b ? b_data_i : a_data_i;
  assign rf_we_o       = rst_ni & (sel_b ? (b_valid_i & rd_nonzero(b_rd_i))
                                         : (a_valid_i & rd_nonzero(a_rd_i)));
  assign hazard_o      = rst_ni & hazard_raw;

  reg_scoreboard u_scoreboard (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .iss_valid_i (iss_valid_i),
    .iss_long_i  (iss_long_i),
    .iss_rs1_i   (iss_rs1_i),
    .iss_rs2_i   (iss_rs2_i),
    .iss_rd_i    (iss_rd_i),
    .clr_valid_i (b_xfer),
    .clr_rd_i    (b_rd_i),
    .hazard_o    (hazard_raw)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd, iss_rs1, iss_rs2, iss_rd;
  logic [31:0] a_data, b_data;
  logic        iss_valid, iss_long;
  logic        hazard, pipe_freeze, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .a_valid_i    (a_valid),
    .a_rd_i       (a_rd),
    .a_data_i     (a_data),
    .b_valid_i    (b_valid),
    .b_ready_o    (b_ready),
    .b_rd_i       (b_rd),
    .b_data_i     (b_data),
    .iss_valid_i  (iss_valid),
    .iss_long_i   (iss_long),
    .iss_rs1_i    (iss_rs1),
    .iss_rs2_i    (iss_rs2),
    .iss_rd_i     (iss_rd),
    .hazard_o     (hazard),
    .pipe_freeze_o(pipe_freeze),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic lng, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd);
    iss_valid = v; iss_long = lng; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
    issue(0, 0, 0, 0, 0);

    // Outputs held quiet while reset is asserted, even with requests present
    #12;
    a_valid = 1; a_rd = 5; #1;
    chk("rst_we", rf_we, 0);
    chk("rst_freeze", pipe_freeze, 0);
    a_valid = 0; b_valid = 1; b_rd = 6; issue(1, 0, 1, 2, 3); #1;
    chk("rst_bready", b_ready, 0);
    chk("rst_hazard", hazard, 0);
    b_valid = 0; issue(0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    cyc();

    // Plain pipeline writeback
    a_valid = 1; a_rd = 5; a_data = 32'h1234_5678; #1;
    chk("a_we", rf_we, 1);
    chk("a_waddr", rf_waddr, 5);
    chk("a_wdata", rf_wdata, 32'h1234_5678);
    chk("a_bready", b_ready, 0);
    a_valid = 0; #1;
    chk("idle_bready", b_ready, 1);
    chk("idle_we", rf_we, 0);
    cyc();

    // Starvation: four blocked cycles, then one forced B cycle
    a_valid = 1; a_rd = 3; a_data = 32'hAAAA_0003;
    b_valid = 1; b_rd = 7; b_data = 32'h7777_0007;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("starve_bready", b_ready, 0);
      chk("starve_waddr", rf_waddr, 3);
      chk("starve_freeze", pipe_freeze, 0);
      cyc();
    end
    chk("force_freeze", pipe_freeze, 1);
    chk("force_bready", b_ready, 1);
    chk("force_we", rf_we, 1);
    chk("force_waddr", rf_waddr, 7);
    chk("force_wdata", rf_wdata, 32'h7777_0007);
    cyc();
    // Counter must have restarted: another four blocked cycles before the next force
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("restart_freeze", pipe_freeze, 0);
      chk("restart_waddr", rf_waddr, 3);
      cyc();
    end
    chk("reforce_freeze", pipe_freeze, 1);
    a_valid = 0; b_valid = 0;
    cyc();
    chk("back_normal", pipe_freeze, 0);

    // Dropping b_valid clears the starvation count
    a_valid = 1;
    for (int k = 0; k < 7; k++) begin
      b_valid = (k != 3);
      cyc();
      chk("drop_freeze", pipe_freeze, 0);
    end
    a_valid = 0; b_valid = 0;
    cyc();

    // Long op to x9, then a consumer stalls until the cycle after B writes x9
    issue(1, 1, 0, 0, 9); #1;
    chk("iss9_hazard", hazard, 0);
    cyc();
    issue(1, 0, 9, 0, 10); #1;
    chk("raw9_hazard", hazard, 1);
    cyc();
    chk("raw9_hazard2", hazard, 1);
    // Long op whose source is pending stalls and must not mark x11
    issue(1, 1, 9, 0, 11); #1;
    chk("stall_long_hazard", hazard, 1);
    cyc();
    issue(1, 0, 9, 0, 10);
    b_valid = 1; b_rd = 9; b_data = 32'h9999_0009; #1;
    chk("b9_bready", b_ready, 1);
    chk("b9_we", rf_we, 1);
    chk("b9_nobypass", hazard, 1);
    cyc();
    b_valid = 0; #1;
    chk("raw9_clear", hazard, 0);
    issue(1, 0, 11, 0, 0); #1;
    chk("x11_not_busy", hazard, 0);

    // Clear and set of x9 in the same cycle: set wins
    issue(1, 1, 0, 0, 9);
    b_valid = 1; b_rd = 9; #1;
    chk("setclr_hazard", hazard, 0);
    cyc();
    b_valid = 0; issue(1, 0, 9, 0, 1); #1;
    chk("setwins_hazard", hazard, 1);
    // B to non-busy x12 is written, x9 remains pending
    b_valid = 1; b_rd = 12; b_data = 32'hC; #1;
    chk("b12_we", rf_we, 1);
    chk("b12_waddr", rf_waddr, 12);
    cyc();
    b_valid = 1; b_rd = 9; #1;
    chk("x9_still_busy", hazard, 1);
    cyc();
    b_valid = 0; #1;
    chk("x9_freed", hazard, 0);

    // x0 writes handshake but never write; x0 never hazards
    a_valid = 1; a_rd = 0; a_data = 32'hDEAD; #1;
    chk("a_x0_we", rf_we, 0);
    a_valid = 0; b_valid = 1; b_rd = 0; b_data = 32'hBEEF; #1;
    chk("b_x0_we", rf_we, 0);
    chk("b_x0_bready", b_ready, 1);
    issue(1, 1, 0, 0, 0); #1;
    chk("x0_hazard", hazard, 0);
    cyc();
    b_valid = 0; #1;
    chk("x0_hazard2", hazard, 0);

    // Reset in the middle of FORCE with x4 pending
    issue(1, 1, 0, 0, 4);
    cyc();
    issue(1, 0, 4, 0, 1); #1;
    chk("x4_busy", hazard, 1);
    a_valid = 1; a_rd = 3; b_valid = 1; b_rd = 7;
    for (int k = 0; k < 4; k++) cyc();
    chk("pre_rst_freeze", pipe_freeze, 1);
    #1 rst_n = 1'b0; #1;
    chk("midrst_freeze", pipe_freeze, 0);
    chk("midrst_hazard", hazard, 0);
    chk("midrst_we", rf_we, 0);
    chk("midrst_bready", b_ready, 0);
    a_valid = 0; b_valid = 0;
    @(negedge clk); rst_n = 1'b1;
    cyc();
    chk("postrst_hazard", hazard, 0);
    chk("postrst_freeze", pipe_freeze, 0);
    issue(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
